// File: rtl/micro_uaz_pkg.sv
// Shared widths and opcode encodings for the micro_uaz 8-bit Harvard core.
package micro_uaz_pkg;
    localparam int DATA_W    = 8;
    localparam int INSTR_W   = 9;
    localparam int PC_W      = 9;
    localparam int REG_IDX_W = 3;
    localparam int OP_W      = 3;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_LD  = 3'b001;
    localparam logic [OP_W-1:0] OP_ST  = 3'b010;
    localparam logic [OP_W-1:0] OP_ADD = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB = 3'b100;
    localparam logic [OP_W-1:0] OP_AND = 3'b101;
    localparam logic [OP_W-1:0] OP_OR  = 3'b110;
    localparam logic [OP_W-1:0] OP_BNZ = 3'b111;
endpackage

// File: rtl/micro_uaz_if.sv
// Instruction and data memory bus between the core (master) and memories (slave).
interface micro_uaz_if;
    import micro_uaz_pkg::*;

    logic [INSTR_W-1:0] i_Instruction;
    logic [DATA_W-1:0]  i_DataInbus;
    logic [PC_W-1:0]    o_Addressinstruction_Bus;
    logic [DATA_W-1:0]  o_Addressdata_Bus;
    logic [DATA_W-1:0]  o_Dataout_Bus;
    logic               ReadWrite;

    modport master (
        input  i_Instruction, i_DataInbus,
        output o_Addressinstruction_Bus, o_Addressdata_Bus, o_Dataout_Bus, ReadWrite
    );

    modport slave (
        output i_Instruction, i_DataInbus,
        input  o_Addressinstruction_Bus, o_Addressdata_Bus, o_Dataout_Bus, ReadWrite
    );
endinterface

// File: rtl/micro_uaz_alu.sv
// Combinational ALU for ADD/SUB/AND/OR; carries and borrows are dropped.
module micro_uaz_alu
    import micro_uaz_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/micro_uaz.sv
// Single-cycle core: decode, 8x8 register file and PC; one instruction per clock.
module micro_uaz
    import micro_uaz_pkg::*;
(
    input  logic      i_Clk,
    input  logic      i_Reset,
    micro_uaz_if.master bus
);
    logic [PC_W-1:0]      r_pc;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];

    logic [OP_W-1:0]      w_op;
    logic [REG_IDX_W-1:0] w_rd;
    logic [REG_IDX_W-1:0] w_rs;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [DATA_W-1:0]    w_alu_y;
    logic [PC_W-1:0]      w_pc_inc;
    logic [PC_W-1:0]      w_pc_next;

    assign w_op     = bus.i_Instruction[8:6];
    assign w_rd     = bus.i_Instruction[5:3];
    assign w_rs     = bus.i_Instruction[2:0];
    assign w_a      = r_regs[w_rd];
    assign w_b      = r_regs[w_rs];
    assign w_pc_inc = r_pc + 1'b1;

    micro_uaz_alu u_alu (
        .i_op (w_op),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_y  (w_alu_y)
    );

    // Branch target is zero-extended from R[rs], so only the low half of the space is reachable.
    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_op == OP_BNZ && w_a != '0)
            w_pc_next = {1'b0, w_b};
    end

    assign bus.o_Addressinstruction_Bus = r_pc;
    assign bus.o_Addressdata_Bus        = i_Reset ? '0 : w_b;
    assign bus.o_Dataout_Bus            = i_Reset ? '0 : w_a;
    assign bus.ReadWrite                = !i_Reset && (w_op == OP_ST);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_pc <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_pc <= w_pc_next;
            case (w_op)
                OP_LD:                         r_regs[w_rd] <= bus.i_DataInbus;
                OP_ADD, OP_SUB, OP_AND, OP_OR: r_regs[w_rd] <= w_alu_y;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_micro_uaz.sv
// Self-checking bench: directed scenarios plus random programs against a reference model.
module tb_micro_uaz;
    logic i_Clk;
    logic i_Reset;
    micro_uaz_if bus ();

    micro_uaz dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int vecs = 0;
    int errs = 0;

    // Reference machine state
    logic [7:0] m_reg [8];
    logic [8:0] m_pc;
    bit         m_known = 0;

    // Apply one instruction for one cycle; check bus against the model, then advance the model.
    task automatic step(input logic rst, input logic [8:0] instr, input logic [7:0] din,
                        output logic [8:0] o_pc, output logic [7:0] o_addr,
                        output logic [7:0] o_dout, output logic o_rw);
        logic [2:0] op, rd, rs;
        logic [7:0] ea, ed, a, b;
        logic       erw;
        @(negedge i_Clk);
        i_Reset = rst;
        bus.i_Instruction = instr;
        bus.i_DataInbus = din;
        #1;
        op = instr[8:6]; rd = instr[5:3]; rs = instr[2:0];
        a = m_reg[rd]; b = m_reg[rs];
        ea  = rst ? 8'h00 : b;
        ed  = rst ? 8'h00 : a;
        erw = !rst && (op == 3'd2);
        o_pc = bus.o_Addressinstruction_Bus; o_addr = bus.o_Addressdata_Bus;
        o_dout = bus.o_Dataout_Bus; o_rw = bus.ReadWrite;
        if (m_known) begin
            vecs++;
            if (o_pc !== m_pc) begin errs++; $display("FAIL pc: got %h want %h", o_pc, m_pc); end
        end
        vecs++;
        if (o_addr !== ea) begin errs++; $display("FAIL daddr: got %h want %h (instr %b)", o_addr, ea, instr); end
        vecs++;
        if (o_dout !== ed) begin errs++; $display("FAIL dout: got %h want %h (instr %b)", o_dout, ed, instr); end
        vecs++;
        if (o_rw !== erw) begin errs++; $display("FAIL rw: got %b want %b (instr %b)", o_rw, erw, instr); end
        @(posedge i_Clk);
        if (rst) begin
            m_pc = 0;
            for (int i = 0; i < 8; i++) m_reg[i] = 0;
            m_known = 1;
        end else begin
            m_pc = m_pc + 9'd1;
            case (op)
                3'd1: m_reg[rd] = din;
                3'd3: m_reg[rd] = 8'((int'(a) + int'(b)) % 256);
                3'd4: m_reg[rd] = 8'((int'(a) - int'(b) + 256) % 256);
                3'd5: m_reg[rd] = a & b;
                3'd6: m_reg[rd] = a | b;
                3'd7: if (a != 0) m_pc = {1'b0, b};
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        step(1'b1, 9'($urandom), 8'($urandom), p, ad, dq, rw);
        step(1'b1, 9'($urandom), 8'($urandom), p, ad, dq, rw);
    endtask

    task automatic test_reset();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        do_reset();
        step(1'b0, 9'b010_000_001, 8'h5A, p, ad, dq, rw);
        vecs++;
        if (p !== 9'h000 || dq !== 8'h00) begin
            errs++; $display("FAIL reset_state: pc %h dout %h want 000/00", p, dq);
        end
    endtask

    task automatic test_load_store();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        do_reset();
        step(1'b0, 9'b001_000_111, 8'h83, p, ad, dq, rw);
        vecs++;
        if (p !== 9'h000 || ad !== 8'h00 || rw !== 1'b0) begin
            errs++; $display("FAIL ld_cycle: pc %h addr %h rw %b want 000/00/0", p, ad, rw);
        end
        step(1'b0, 9'b010_000_001, 8'h00, p, ad, dq, rw);
        vecs++;
        if (p !== 9'h001 || dq !== 8'h83 || ad !== 8'h00 || rw !== 1'b1) begin
            errs++; $display("FAIL st_cycle: pc %h dout %h addr %h rw %b want 001/83/00/1", p, dq, ad, rw);
        end
        step(1'b0, 9'b000_000_000, 8'h00, p, ad, dq, rw);
        vecs++;
        if (p !== 9'h002) begin errs++; $display("FAIL pc_advance: got %h want 002", p); end
    endtask

    task automatic test_alu();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        do_reset();
        step(1'b0, 9'b001_001_000, 8'h0F, p, ad, dq, rw);
        step(1'b0, 9'b001_010_000, 8'h02, p, ad, dq, rw);
        step(1'b0, 9'b011_001_010, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b010_001_000, 8'h00, p, ad, dq, rw);
        vecs++; if (dq !== 8'h11) begin errs++; $display("FAIL alu_add: got %h want 11", dq); end
        step(1'b0, 9'b100_010_001, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b010_010_000, 8'h00, p, ad, dq, rw);
        vecs++; if (dq !== 8'hF1) begin errs++; $display("FAIL alu_sub: got %h want f1", dq); end
        step(1'b0, 9'b101_001_010, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b010_001_000, 8'h00, p, ad, dq, rw);
        vecs++; if (dq !== 8'h11) begin errs++; $display("FAIL alu_and: got %h want 11", dq); end
        step(1'b0, 9'b110_010_001, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b010_010_000, 8'h00, p, ad, dq, rw);
        vecs++; if (dq !== 8'hF1) begin errs++; $display("FAIL alu_or: got %h want f1", dq); end
        step(1'b0, 9'b001_011_000, 8'h9C, p, ad, dq, rw);
        step(1'b0, 9'b100_011_011, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b010_011_000, 8'h00, p, ad, dq, rw);
        vecs++; if (dq !== 8'h00) begin errs++; $display("FAIL alu_sub_self: got %h want 00", dq); end
    endtask

    task automatic test_branch();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        do_reset();
        step(1'b0, 9'b001_010_000, 8'h05, p, ad, dq, rw);
        step(1'b0, 9'b001_110_000, 8'h40, p, ad, dq, rw);
        step(1'b0, 9'b111_010_110, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b001_010_000, 8'h00, p, ad, dq, rw);
        vecs++; if (p !== 9'h040) begin errs++; $display("FAIL bnz_taken: got %h want 040", p); end
        step(1'b0, 9'b111_010_110, 8'h00, p, ad, dq, rw);
        step(1'b0, 9'b000_000_000, 8'h00, p, ad, dq, rw);
        vecs++; if (p !== 9'h042) begin errs++; $display("FAIL bnz_not_taken: got %h want 042", p); end
    endtask

    task automatic test_pc_wrap();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        logic [8:0] last;
        do_reset();
        last = 9'h000;
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 9'b000_000_000, 8'h00, p, ad, dq, rw);
            last = p;
        end
        vecs++; if (last !== 9'h1FF) begin errs++; $display("FAIL pc_top: got %h want 1ff", last); end
        step(1'b0, 9'b000_000_000, 8'h00, p, ad, dq, rw);
        vecs++; if (p !== 9'h000) begin errs++; $display("FAIL pc_wrap: got %h want 000", p); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        for (int i = 0; i < 8; i++)
            step(1'b0, {3'b001, 3'(i), 3'b000}, 8'(8'hA0 + i), p, ad, dq, rw);
        step(1'b1, 9'b010_000_001, 8'h00, p, ad, dq, rw);
        vecs++;
        if (rw !== 1'b0 || ad !== 8'h00 || dq !== 8'h00) begin
            errs++; $display("FAIL reset_mid_outputs: rw %b addr %h dout %h want 0/00/00", rw, ad, dq);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, {3'b010, 3'(i), 3'b000}, 8'h00, p, ad, dq, rw);
            vecs++;
            if (dq !== 8'h00 || p !== 9'(i)) begin
                errs++; $display("FAIL reset_mid_reg%0d: dout %h pc %h want 00/%h", i, dq, p, 9'(i));
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] p; logic [7:0] ad, dq; logic rw;
        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, 9'($urandom), 8'($urandom), p, ad, dq, rw);
    endtask

    initial begin
        i_Reset = 1'b1;
        bus.i_Instruction = '0;
        bus.i_DataInbus = '0;
        m_pc = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        test_reset();
        test_load_store();
        test_alu();
        test_branch();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
